rtc_field_editor: RTL and testbench
===================================

Name: rtc_field_editor

Overview:
Edit-mode controller for the RTC configuration datapath. Consumes the 4-bit field pointer from the field-selection FSM and up/down pulses, and keeps BCD shadow copies of the 9 editable fields. Applies range-limited increment/decrement to the selected field. On leaving edit mode, sequences a write burst of only the modified fields to the RTC register write port over a req/ack handshake.

Parameters:
ACK_TIMEOUT, 255, cycles to wait for wr_ack before aborting the burst
TO_W, 8, width of the timeout counter; must hold ACK_TIMEOUT

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
interr  in  1  edit-mode enable (level)
puntero  in  4  selected field: 1..9 valid; 0 or >9 means no field selected
arriba  in  1  one-cycle increment pulse
abajo  in  1  one-cycle decrement pulse
snap_data  in  72  current RTC values in BCD, byte k-1 = field k
wr_req  out  1  write request
wr_addr  out  8  RTC register address
wr_data  out  8  BCD data to write
wr_ack  in  1  one-cycle write acknowledge
field_value  out  8  shadow value of the selected field; 0 when none is selected
busy  out  1  high in COMMIT and WAIT_ACK
err  out  1  sticky ack-timeout flag; cleared when the next edit session starts

Behaviour:
- Reset: all outputs 0, shadows 0, dirty mask 0, state IDLE. Reset wins over every other input in any state, including mid-burst, so wr_req drops on the next edge.
- Field map (field: range, address): 1 clk_seg 00-59 0x21; 2 clk_min 00-59 0x22; 3 clk_hor 00-23 0x23; 4 dia 01-max 0x24; 5 mes 01-12 0x25; 6 year 00-99 0x26; 7 tmr_seg 00-59 0x41; 8 tmr_min 00-59 0x42; 9 tmr_hor 00-23 0x43.
- Day max: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; Feb 29 if the BCD year is divisible by 4, else 28. Leap test: tens even and units in {0,4,8}, or tens odd and units in {2,6}.
- State IDLE: on an interr 0->1 edge, load all 9 shadows from snap_data, clear dirty, clear err, go to EDIT next cycle.
- State EDIT, on arriba XOR abajo with a valid puntero:
  - Selected field steps by +/-1 in BCD and takes effect the next cycle.
  - Wraps max->min and min->max; for example, 59 +1 -> 00, and day 01 -1 -> max.
  - The field's dirty bit is set.
- If arriba and abajo arrive together, or puntero is invalid, nothing changes.
- After a change to mes or year, if dia exceeds the new max, dia is clamped to max the following cycle and marked dirty.
- EDIT -> COMMIT when interr falls. If dirty is 0, go straight to IDLE with no bus activity.
- State COMMIT: scan fields in ascending index for the lowest dirty bit. When found, drive wr_addr/wr_data, assert wr_req, and go to WAIT_ACK. When no dirty bits remain, go to IDLE.
- State WAIT_ACK:
  - wr_req, wr_addr and wr_data are held stable until wr_ack.
  - On wr_ack: deassert wr_req next cycle, clear that dirty bit, return to COMMIT.
  - Timeout: after ACK_TIMEOUT cycles with no ack, drop wr_req, set err, clear all dirty bits, go to IDLE.
- Each write costs at least 2 cycles (COMMIT, then WAIT_ACK), and wr_req is deasserted for at least 1 cycle between writes.
- interr edges during COMMIT or WAIT_ACK are ignored. A new session starts only from IDLE on a fresh rising edge.
- field_value is registered and follows puntero and the shadows with 1-cycle latency.

Decomposition:
- Package rtc_edit_pkg holds:
  - state encodings (IDLE, EDIT, COMMIT, WAIT_ACK);
  - field index constants 1..9, matching the selection FSM encoding;
  - address constants and per-field min/max BCD constants.
- One sub-module, bcd_step: combinational BCD +/-1 with min/max wrap, instantiated once and muxed by puntero.

Test Plan:
1. Reset mid-burst: reset while wr_req=1 -> next cycle wr_req=0, busy=0, state IDLE, field_value=0.
2. Seconds wrap: snap sec=0x59, puntero=1, one arriba pulse, interr falls -> field_value shows 0x00, then exactly one write addr 0x21 data 0x00; ack after 3 cycles -> busy falls 2 cycles later.
3. Day clamp: snap dia=0x31 mes=0x01 year=0x23; puntero=5, arriba -> mes 0x02, dia clamped to 0x28. Commit writes 0x24/0x28 then 0x25/0x02 in that order.
4. Leap year: year=0x24 mes=0x02 dia=0x28; puntero=4, arriba -> 0x29; arriba again -> 0x01.
5. Guards: arriba and abajo together, and puntero=0 with arriba -> shadows and dirty unchanged; interr falls -> no wr_req ever asserted.
6. Timeout: dirty tmr_hor, wr_ack held 0 -> wr_req high exactly ACK_TIMEOUT cycles, then err=1 and IDLE; the next session start clears err.

Source files
------------

// File: rtl/rtc_edit_pkg.sv
// Shared encodings for the RTC edit-mode controller: FSM states, field indices,
// register addresses and per-field BCD ranges.
package rtc_edit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EDIT,
    ST_COMMIT,
    ST_WAIT_ACK
  } state_t;

  // Field indices match the encoding produced by the field-selection FSM
  localparam logic [3:0] F_CLK_SEG = 4'd1;
  localparam logic [3:0] F_CLK_MIN = 4'd2;
  localparam logic [3:0] F_CLK_HOR = 4'd3;
  localparam logic [3:0] F_DIA     = 4'd4;
  localparam logic [3:0] F_MES     = 4'd5;
  localparam logic [3:0] F_YEAR    = 4'd6;
  localparam logic [3:0] F_TMR_SEG = 4'd7;
  localparam logic [3:0] F_TMR_MIN = 4'd8;
  localparam logic [3:0] F_TMR_HOR = 4'd9;

  function automatic logic [7:0] field_addr(input logic [3:0] f);
    case (f)
      F_CLK_SEG: return 8'h21;
      F_CLK_MIN: return 8'h22;
      F_CLK_HOR: return 8'h23;
      F_DIA:     return 8'h24;
      F_MES:     return 8'h25;
      F_YEAR:    return 8'h26;
      F_TMR_SEG: return 8'h41;
      F_TMR_MIN: return 8'h42;
      F_TMR_HOR: return 8'h43;
      default:   return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] field_min(input logic [3:0] f);
    return (f == F_DIA || f == F_MES) ? 8'h01 : 8'h00;
  endfunction

  // Static upper bound; the day field's real bound comes from day_max()
  function automatic logic [7:0] field_max(input logic [3:0] f);
    case (f)
      F_CLK_SEG, F_CLK_MIN, F_TMR_SEG, F_TMR_MIN: return 8'h59;
      F_CLK_HOR, F_TMR_HOR:                       return 8'h23;
      F_DIA:                                      return 8'h31;
      F_MES:                                      return 8'h12;
      F_YEAR:                                     return 8'h99;
      default:                                    return 8'h00;
    endcase
  endfunction

  // BCD year divisible by 4: even tens with units 0/4/8, odd tens with units 2/6
  function automatic logic [7:0] day_max(input logic [7:0] mes, input logic [7:0] year);
    logic leap;
    leap = year[4] ? (year[3:0] == 4'd2 || year[3:0] == 4'd6)
                   : (year[3:0] == 4'd0 || year[3:0] == 4'd4 || year[3:0] == 4'd8);
    case (mes)
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      8'h02:                      return leap ? 8'h29 : 8'h28;
      default:                    return 8'h31;
    endcase
  endfunction

endpackage

// File: rtl/bcd_step.sv
// Combinational two-digit BCD increment/decrement with wrap between min and max.
module bcd_step (
  input  logic [7:0] val,
  input  logic       up,
  input  logic [7:0] min_val,
  input  logic [7:0] max_val,
  output logic [7:0] result
);

  always_comb begin
    result = val;
    if (up) begin
      if (val >= max_val)       result = min_val;
      else if (val[3:0] >= 4'd9) result = {val[7:4] + 4'd1, 4'd0};
      else                       result = {val[7:4], val[3:0] + 4'd1};
    end else begin
      if (val <= min_val)        result = max_val;
      else if (val[3:0] == 4'd0) result = {val[7:4] - 4'd1, 4'd9};
      else                       result = {val[7:4], val[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/rtc_field_editor.sv
// Edit-mode controller: BCD shadow copies of the nine editable RTC fields, up/down
// editing with day clamping, and a req/ack write burst of only the modified fields.
module rtc_field_editor
  import rtc_edit_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        interr,
  input  logic [3:0]  puntero,
  input  logic        arriba,
  input  logic        abajo,
  input  logic [71:0] snap_data,
  output logic        wr_req,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  input  logic        wr_ack,
  output logic [7:0]  field_value,
  output logic        busy,
  output logic        err
);

  state_t          state;
  logic [7:0]      shadow [1:9];
  logic [8:0]      dirty;
  logic            interr_q;
  logic            clamp_pend;
  logic [3:0]      cur_idx;
  logic [TO_W-1:0] to_cnt;

  logic       sel_valid, edit_hit, found;
  logic [7:0] sel_val, dmax, step_min, step_max, step_val, scan_data;
  logic [3:0] scan_idx;

  assign sel_valid = (puntero != 4'd0) && (puntero <= 4'd9);
  assign edit_hit  = sel_valid && (arriba ^ abajo);
  assign dmax      = day_max(shadow[F_MES], shadow[F_YEAR]);
  assign step_min  = field_min(puntero);
  assign step_max  = (puntero == F_DIA) ? dmax : field_max(puntero);

  always_comb begin
    sel_val = 8'h00;
    for (int k = 1; k <= 9; k++)
      if (puntero == 4'(k)) sel_val = shadow[k];
  end

  // Lowest-index dirty field wins; scanning downward leaves the lowest one last
  always_comb begin
    found     = 1'b0;
    scan_idx  = 4'd0;
    scan_data = 8'h00;
    for (int k = 9; k >= 1; k--) begin
      if (dirty[k-1]) begin
        found     = 1'b1;
        scan_idx  = 4'(k);
        scan_data = shadow[k];
      end
    end
  end

  bcd_step u_step (
    .val     (sel_val),
    .up      (arriba),
    .min_val (step_min),
    .max_val (step_max),
    .result  (step_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      dirty       <= '0;
      interr_q    <= 1'b0;
      clamp_pend  <= 1'b0;
      cur_idx     <= 4'd0;
      to_cnt      <= '0;
      wr_req      <= 1'b0;
      wr_addr     <= 8'h00;
      wr_data     <= 8'h00;
      field_value <= 8'h00;
      busy        <= 1'b0;
      err         <= 1'b0;
      for (int k = 1; k <= 9; k++) shadow[k] <= 8'h00;
    end else begin
      interr_q    <= interr;
      field_value <= sel_valid ? sel_val : 8'h00;
      case (state)
        ST_IDLE: begin
          if (interr && !interr_q) begin
            for (int k = 1; k <= 9; k++) shadow[k] <= snap_data[8*(k-1) +: 8];
            dirty      <= '0;
            err        <= 1'b0;
            clamp_pend <= 1'b0;
            state      <= ST_EDIT;
          end
        end
        ST_EDIT: begin
          if (!interr) begin
            state <= (dirty == '0) ? ST_IDLE : ST_COMMIT;
            busy  <= (dirty != '0);
          end else if (edit_hit) begin
            for (int k = 1; k <= 9; k++) begin
              if (puntero == 4'(k)) begin
                shadow[k]  <= step_val;
                dirty[k-1] <= 1'b1;
              end
            end
            if (puntero == F_MES || puntero == F_YEAR) clamp_pend <= 1'b1;
          end
          // Day clamp lands one cycle after a month/year change and overrides a same-cycle day edit
          if (clamp_pend) begin
            clamp_pend <= 1'b0;
            if (shadow[F_DIA] > dmax) begin
              shadow[F_DIA] <= dmax;
              dirty[3]      <= 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          if (found) begin
            wr_addr <= field_addr(scan_idx);
            wr_data <= scan_data;
            wr_req  <= 1'b1;
            cur_idx <= scan_idx;
            to_cnt  <= '0;
            state   <= ST_WAIT_ACK;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_WAIT_ACK: begin
          if (wr_ack) begin
            wr_req <= 1'b0;
            for (int k = 1; k <= 9; k++)
              if (cur_idx == 4'(k)) dirty[k-1] <= 1'b0;
            state <= ST_COMMIT;
          end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
            wr_req <= 1'b0;
            err    <= 1'b1;
            dirty  <= '0;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_field_editor.sv
// Scoreboard bench for rtc_field_editor: a decimal reference model predicts field values
// and the ordered write burst; a monitor checks every write the DUT issues.
module tb_rtc_field_editor;

  localparam int ACK_TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset, interr, arriba, abajo, wr_req, wr_ack, busy, err;
  logic [3:0]  puntero;
  logic [71:0] snap_data;
  logic [7:0]  wr_addr, wr_data, field_value;

  always #5 clk = ~clk;

  rtc_field_editor #(.ACK_TIMEOUT(ACK_TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .interr(interr), .puntero(puntero),
    .arriba(arriba), .abajo(abajo), .snap_data(snap_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .field_value(field_value), .busy(busy), .err(err)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  int  vectors = 0;
  int  miscompares = 0;
  int  m_val [1:9];
  bit  m_dirty [1:9];
  wr_t exp_q [$];
  bit  ack_en = 1'b1;
  bit  ack_rand = 1'b1;
  int  ack_delay = 0;

  function automatic int days(input int mes, input int year);
    case (mes)
      4, 6, 9, 11: return 30;
      2:           return (year % 4 == 0) ? 29 : 28;
      default:     return 31;
    endcase
  endfunction

  function automatic int fmin(input int k);
    return (k == 4 || k == 5) ? 1 : 0;
  endfunction

  function automatic int fmax(input int k);
    case (k)
      1, 2, 7, 8: return 59;
      3, 9:       return 23;
      4:          return days(m_val[5], m_val[6]);
      5:          return 12;
      default:    return 99;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic logic [7:0] faddr(input int k);
    if (k <= 6) return 8'(32 + k);
    return 8'(64 + k - 6);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vals();
    m_val[5] = int'($urandom_range(1, 12));
    m_val[6] = int'($urandom_range(0, 99));
    m_val[4] = int'($urandom_range(1, days(m_val[5], m_val[6])));
    foreach (m_val[k])
      if (k != 4 && k != 5 && k != 6) m_val[k] = int'($urandom_range(fmin(k), fmax(k)));
  endtask

  task automatic start_session();
    snap_data = '0;
    for (int k = 1; k <= 9; k++) begin
      snap_data[8*(k-1) +: 8] = to_bcd(m_val[k]);
      m_dirty[k] = 1'b0;
    end
    interr = 1'b1;
    tick();
    tick();
    chk("session_err", 32'(err), 32'd0);
  endtask

  task automatic peek(input int p);
    puntero = 4'(p);
    tick();
    tick();
    chk("field_value", 32'(field_value), (p >= 1 && p <= 9) ? 32'(to_bcd(m_val[p])) : 32'd0);
  endtask

  task automatic edit(input int p, input bit up, input bit dn);
    int v;
    puntero = 4'(p);
    arriba  = up;
    abajo   = dn;
    tick();
    arriba = 1'b0;
    abajo  = 1'b0;
    if (p >= 1 && p <= 9 && (up ^ dn)) begin
      v = m_val[p];
      if (up) v = (v >= fmax(p)) ? fmin(p) : v + 1;
      else    v = (v <= fmin(p)) ? fmax(p) : v - 1;
      m_val[p]   = v;
      m_dirty[p] = 1'b1;
      if ((p == 5 || p == 6) && m_val[4] > days(m_val[5], m_val[6])) begin
        m_val[4]   = days(m_val[5], m_val[6]);
        m_dirty[4] = 1'b1;
      end
    end
    tick();
    tick();
    tick();
    chk("field_value", 32'(field_value), (p >= 1 && p <= 9) ? 32'(to_bcd(m_val[p])) : 32'd0);
  endtask

  task automatic push_writes();
    wr_t w;
    for (int k = 1; k <= 9; k++) begin
      if (m_dirty[k]) begin
        w.addr = faddr(k);
        w.data = to_bcd(m_val[k]);
        exp_q.push_back(w);
        m_dirty[k] = 1'b0;
      end
    end
  endtask

  task automatic end_session();
    int n;
    interr = 1'b0;
    push_writes();
    tick();
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    chk("burst_done_busy", 32'(busy), 32'd0);
    chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  // Ack responder: pulses wr_ack once per request after ack_delay cycles of wr_req
  initial begin
    int cnt;
    wr_ack = 1'b0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      wr_ack = 1'b0;
      if (wr_req && ack_en) begin
        if (cnt >= ack_delay) begin
          wr_ack = 1'b1;
          cnt = 0;
          if (ack_rand) ack_delay = int'($urandom_range(0, 5));
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: each new request is matched against the scoreboard, then held values are checked
  initial begin
    logic       prev;
    logic [7:0] ha, hd;
    wr_t        e;
    prev = 1'b0;
    ha = 8'h00;
    hd = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (wr_req && !prev) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("wr_data", 32'(wr_data), 32'(e.data));
        end
        ha = wr_addr;
        hd = wr_data;
      end else if (wr_req) begin
        chk("wr_addr_hold", 32'(wr_addr), 32'(ha));
        chk("wr_data_hold", 32'(wr_data), 32'(hd));
      end
      prev = wr_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n, cnt;
    bit seen;
    reset = 1'b1; interr = 1'b0; puntero = 4'd0; arriba = 1'b0; abajo = 1'b0; snap_data = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_field_value", 32'(field_value), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);

    // Seconds wrap, then a single write acked after 3 cycles
    rand_vals();
    m_val[1] = 59;
    start_session();
    edit(1, 1'b1, 1'b0);
    chk("sec_wrap", 32'(field_value), 32'h00);
    ack_rand = 1'b0;
    ack_delay = 3;
    interr = 1'b0;
    push_writes();
    seen = 1'b0;
    for (n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = wr_ack;
    end
    chk("ack_seen", 32'(seen), 32'd1);
    tick();
    chk("busy_after_ack_1", 32'(busy), 32'd1);
    tick();
    chk("busy_after_ack_2", 32'(busy), 32'd0);
    chk("sec_writes_left", 32'(exp_q.size()), 32'd0);
    ack_rand = 1'b1;
    tick();

    // February clamp from a month change
    rand_vals();
    m_val[4] = 31; m_val[5] = 1; m_val[6] = 23;
    start_session();
    edit(5, 1'b1, 1'b0);
    chk("mes_feb", 32'(field_value), 32'h02);
    peek(4);
    chk("dia_clamped", 32'(field_value), 32'h28);
    end_session();

    // Leap year day wrap
    rand_vals();
    m_val[4] = 28; m_val[5] = 2; m_val[6] = 24;
    start_session();
    edit(4, 1'b1, 1'b0);
    chk("leap_29", 32'(field_value), 32'h29);
    edit(4, 1'b1, 1'b0);
    chk("leap_wrap_01", 32'(field_value), 32'h01);
    edit(4, 1'b0, 1'b1);
    chk("leap_back_29", 32'(field_value), 32'h29);
    end_session();

    // Guards: both pulses together, invalid pointers
    rand_vals();
    start_session();
    edit(3, 1'b1, 1'b1);
    edit(0, 1'b1, 1'b0);
    edit(10, 1'b0, 1'b1);
    edit(15, 1'b1, 1'b0);
    peek(6);
    end_session();

    // Ack timeout on tmr_hor, with an interr pulse that must be ignored mid-burst
    ack_en = 1'b0;
    rand_vals();
    start_session();
    edit(9, 1'b1, 1'b0);
    interr = 1'b0;
    push_writes();
    tick();
    cnt = 0;
    for (n = 0; n < 600; n++) begin
      if (n == 100) interr = 1'b1;
      if (n == 120) interr = 1'b0;
      tick();
      if (wr_req) cnt++;
      else if (cnt > 0) break;
    end
    chk("req_cycles", 32'(cnt), 32'(ACK_TIMEOUT));
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_busy", 32'(busy), 32'd0);
    tick();
    tick();
    chk("err_sticky", 32'(err), 32'd1);
    chk("timeout_writes_left", 32'(exp_q.size()), 32'd0);
    ack_en = 1'b1;
    rand_vals();
    start_session();
    end_session();

    // Reset in the middle of a burst
    ack_en = 1'b0;
    rand_vals();
    start_session();
    edit(1, 1'b1, 1'b0);
    edit(2, 1'b0, 1'b1);
    interr = 1'b0;
    push_writes();
    seen = 1'b0;
    for (n = 0; n < 20 && !seen; n++) begin
      tick();
      seen = wr_req;
    end
    chk("burst_started", 32'(seen), 32'd1);
    puntero = 4'd1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("midrst_wr_req", 32'(wr_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_field_value", 32'(field_value), 32'd0);
    tick();
    chk("postrst_field_value", 32'(field_value), 32'd0);
    chk("postrst_wr_req", 32'(wr_req), 32'd0);
    ack_en = 1'b1;

    // Randomized sessions
    for (int s = 0; s < 25; s++) begin
      rand_vals();
      start_session();
      for (int e = 0; e < int'($urandom_range(3, 10)); e++) begin
        n = int'($urandom_range(0, 3));
        edit(int'($urandom_range(0, 11)), n[0], n[1]);
      end
      end_session();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
